// File: rtl/tc_to_fp_encoder.sv
// tc_to_fp_encoder: two's-complement sample to sign/exp/significand code.
// 3-stage valid/ready pipeline: sign-mag, extract, round/saturate.
// Ports: clk, rst_n, in_valid/in_ready/in_data,
//        out_valid/out_ready, out_s, out_e, out_f, out_sat.
module tc_to_fp_encoder #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_f,
  output logic             out_sat
);

  localparam int MW   = IN_W - 1;
  localparam int PW   = $clog2(MW);
  // Wide enough for p-MAN_W+2 and for 2^EXP_W, so no wrap before clamp.
  localparam int EI_W = (EXP_W + 1 > PW + 1) ? EXP_W + 1 : PW + 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  logic adv;
  logic v1, v2, v3;

  assign adv       = out_ready | ~v3;
  assign in_ready  = adv;
  assign out_valid = v3;

  // stage 1: sign-magnitude
  logic          s0, sat0, mneg;
  logic [MW-1:0] m0;

  always_comb begin
    s0   = in_data[IN_W-1];
    mneg = s0 & ~|in_data[MW-1:0];
    m0   = in_data[MW-1:0];
    if (s0) m0 = ~in_data[MW-1:0] + MW'(1);
    // -2^(IN_W-1) has no positive twin: pin to the largest magnitude
    if (mneg) m0 = '1;
    sat0 = mneg;
  end

  logic          s1, sat1;
  logic [MW-1:0] m1;

  // stage 2: MSB search and significand extract
  logic [PW-1:0]    p, sh;
  logic [EI_W-1:0]  e2n;
  logic [MAN_W-1:0] f2n;
  logic             r2n;

  always_comb begin
    p   = '0;
    sh  = '0;
    e2n = '0;
    f2n = m1[MAN_W-1:0];
    r2n = 1'b0;
    for (int i = 0; i < MW; i++)
      if (m1[i]) p = PW'(i);
    if (p >= PW'(MAN_W)) begin
      // sh is the position of the round bit, just below F
      sh  = p - PW'(MAN_W);
      f2n = MAN_W'(m1 >> (sh + PW'(1)));
      r2n = m1[sh];
      e2n = EI_W'(sh) + EI_W'(1);
    end
  end

  logic             s2, sat2, r2;
  logic [EI_W-1:0]  e2;
  logic [MAN_W-1:0] f2;

  // stage 3: round half-up, renormalise, clamp
  logic [MAN_W:0]   fr;
  logic [EI_W-1:0]  e3;
  logic [MAN_W-1:0] f3;
  logic             clamp;

  always_comb begin
    fr = {1'b0, f2} + {{MAN_W{1'b0}}, r2};
    e3 = e2;
    f3 = fr[MAN_W-1:0];
    if (fr[MAN_W]) begin
      e3 = e2 + EI_W'(1);
      f3 = {1'b1, {(MAN_W-1){1'b0}}};
    end
    // e3 >= e2, so this also catches overflow before rounding
    clamp = e3 > EI_W'(EMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1      <= 1'b0;
      sat1    <= 1'b0;
      m1      <= '0;
      s2      <= 1'b0;
      sat2    <= 1'b0;
      r2      <= 1'b0;
      e2      <= '0;
      f2      <= '0;
      out_s   <= 1'b0;
      out_e   <= '0;
      out_f   <= '0;
      out_sat <= 1'b0;
    end else if (adv) begin
      v1      <= in_valid;
      s1      <= s0;
      sat1    <= sat0;
      m1      <= m0;
      v2      <= v1;
      s2      <= s1;
      sat2    <= sat1;
      r2      <= r2n;
      e2      <= e2n;
      f2      <= f2n;
      v3      <= v2;
      out_s   <= s2;
      out_e   <= clamp ? '1 : e3[EXP_W-1:0];
      out_f   <= clamp ? '1 : f3;
      out_sat <= sat2 | clamp;
    end
  end

endmodule

// File: tb/tb_tc_to_fp_encoder.sv
// tb_tc_to_fp_encoder: directed checks of tc_to_fp_encoder
// (IN_W=12, EXP_W=3, MAN_W=4), one task per scenario.
module tb_tc_to_fp_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        out_sat;

  int n_assert = 0;
  int n_fail   = 0;

  tc_to_fp_encoder #(.IN_W(12), .EXP_W(3), .MAN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: {s, e[2:0], f[3:0], sat}
  function automatic logic [8:0] model(input logic [11:0] d);
    int v, m, e, f, r;
    logic s, sat;
    v = int'($signed(d));
    s = v < 0;
    m = s ? -v : v;
    sat = 1'b0;
    if (m > 2047) begin m = 2047; sat = 1'b1; end
    e = 0; f = m; r = 0;
    while (f >= 16) begin r = f & 1; f = f >> 1; e++; end
    f = f + r;
    if (f == 16) begin f = 8; e++; end
    if (e > 7) begin e = 7; f = 15; sat = 1'b1; end
    return {s, 3'(e), 4'(f), sat};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({out_valid, out_s, out_e, out_f, out_sat} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 0",
               {out_valid, out_s, out_e, out_f, out_sat});
    end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_one(input string nm, input logic [11:0] d,
                         input logic xs, input logic [2:0] xe,
                         input logic [3:0] xf, input logic xsat);
    int lat;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    n_assert++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d want 3", nm, lat);
    end
    n_assert++;
    if ({out_s, out_e, out_f, out_sat} !== {xs, xe, xf, xsat}) begin
      n_fail++;
      $display("FAIL %s: got s=%b e=%0d f=%b sat=%b want s=%b e=%0d f=%b sat=%b",
               nm, out_s, out_e, out_f, out_sat, xs, xe, xf, xsat);
    end
  endtask

  task automatic test_zero_small();
    run_one("zero", 12'h000, 1'b0, 3'd0, 4'b0000, 1'b0);
    run_one("small_0f", 12'h00F, 1'b0, 3'd0, 4'b1111, 1'b0);
  endtask

  task automatic test_round();
    run_one("round_125", 12'h07D, 1'b0, 3'd4, 4'b1000, 1'b0);
    run_one("neg_422", 12'hE5A, 1'b1, 3'd5, 4'b1101, 1'b0);
    run_one("round_31", 12'h01F, 1'b0, 3'd2, 4'b1000, 1'b0);
  endtask

  task automatic test_saturation();
    run_one("sat_800", 12'h800, 1'b1, 3'd7, 4'b1111, 1'b1);
    run_one("sat_7ff", 12'h7FF, 1'b0, 3'd7, 4'b1111, 1'b1);
  endtask

  task automatic test_throughput();
    logic [11:0] vec [20];
    logic [8:0]  exp_q [$];
    logic [8:0]  x;
    int first, last, got, cyc;
    vec = '{12'h001, 12'h0FF, 12'hF00, 12'h123, 12'h800, 12'h7FF,
            12'h010, 12'hFFF, 12'h3A5, 12'hC5B, 12'h018, 12'h017,
            12'h0F8, 12'h0F7, 12'h400, 12'hBFF, 12'h055, 12'hAAA,
            12'h000, 12'h7C0};
    first = -1; last = -1; got = 0; cyc = 0;
    while (got < 20 && cyc < 60) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = cyc < 20;
      in_data   = (cyc < 20) ? vec[cyc] : 12'h000;
      #1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        x = exp_q.pop_front();
        got++;
        n_assert++;
        if ({out_s, out_e, out_f, out_sat} !== x) begin
          n_fail++;
          $display("FAIL stream_%0d: got %b want %b", got,
                   {out_s, out_e, out_f, out_sat}, x);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
      cyc++;
    end
    in_valid = 1'b0;
    n_assert++;
    if (first != 3) begin
      n_fail++;
      $display("FAIL stream_first_latency: got %0d want 3", first);
    end
    n_assert++;
    if (got != 20 || last != 22) begin
      n_fail++;
      $display("FAIL stream_rate: got %0d results last cycle %0d want 20 at 22",
               got, last);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] vec [8];
    logic [8:0]  exp_q [$];
    logic [8:0]  x, held;
    int idx, got, cyc;
    vec = '{12'h07D, 12'hE5A, 12'h00F, 12'h800, 12'h010, 12'h7FF,
            12'h123, 12'hF00};
    idx = 0; got = 0; cyc = 0; held = '0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = cyc >= 5;
      in_valid  = idx < 8;
      in_data   = (idx < 8) ? vec[idx] : 12'h000;
      #1;
      if (cyc == 3) held = {out_s, out_e, out_f, out_sat};
      if (cyc == 3 || cyc == 4) begin
        n_assert++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_stall_c%0d: in_ready=%b out_valid=%b want 0/1",
                   cyc, in_ready, out_valid);
        end
        n_assert++;
        if ({out_s, out_e, out_f, out_sat} !== model(vec[0])) begin
          n_fail++;
          $display("FAIL bp_hold_c%0d: got %b want %b held %b", cyc,
                   {out_s, out_e, out_f, out_sat}, model(vec[0]), held);
        end
      end
      if (cyc == 5) begin
        n_assert++;
        if (idx != 3) begin
          n_fail++;
          $display("FAIL bp_in_flight: got %0d want 3", idx);
        end
      end
      if (out_valid && out_ready) begin
        x = exp_q.pop_front();
        got++;
        n_assert++;
        if ({out_s, out_e, out_f, out_sat} !== x) begin
          n_fail++;
          $display("FAIL bp_out_%0d: got %b want %b", got,
                   {out_s, out_e, out_f, out_sat}, x);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_assert++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL bp_delivered: got %0d want 8", got);
    end
  endtask

  task automatic test_reset_midstream();
    int ghost;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 12'h07D + 12'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_assert++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_valid: got %b want 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({out_valid, out_s, out_e, out_f, out_sat} !== 10'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_async_clear: got %b in_ready=%b want 0 / 1",
               {out_valid, out_s, out_e, out_f, out_sat}, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ghost = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    n_assert++;
    if (ghost != 0) begin
      n_fail++;
      $display("FAIL mid_ghost: got %0d stale results want 0", ghost);
    end
    run_one("post_reset_010", 12'h010, 1'b0, 3'd1, 4'b1000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_small();
    test_round();
    test_saturation();
    test_throughput();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
